// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } arb_owner_e;

  localparam logic [1:0] MEM_W_BYTE = 2'd0;
  localparam logic [1:0] MEM_W_HALF = 2'd1;
  localparam logic [1:0] MEM_W_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, load/store port and memory bus of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
interface mem_port_arbiter_if;

  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        o_inst_ack;
  logic [31:0] o_inst_rdata;

  logic        i_data_req;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wdata;
  logic [1:0]  i_data_width;
  logic        i_data_we;
  logic        i_data_zext;
  logic        o_data_ack;
  logic [31:0] o_data_rdata;

  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [1:0]  o_mem_width;
  logic        o_mem_we;
  logic        o_mem_zext;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  logic        o_timeout;

  modport slave (
    input  i_inst_req, i_inst_addr,
    input  i_data_req, i_data_addr, i_data_wdata, i_data_width, i_data_we, i_data_zext,
    input  i_mem_ack, i_mem_rdata,
    output o_inst_ack, o_inst_rdata, o_data_ack, o_data_rdata,
    output o_mem_req, o_mem_addr, o_mem_wdata, o_mem_width, o_mem_we, o_mem_zext,
    output o_timeout
  );

  modport master (
    output i_inst_req, i_inst_addr,
    output i_data_req, i_data_addr, i_data_wdata, i_data_width, i_data_we, i_data_zext,
    output i_mem_ack, i_mem_rdata,
    input  o_inst_ack, o_inst_rdata, o_data_ack, o_data_rdata,
    input  o_mem_req, o_mem_addr, o_mem_wdata, o_mem_width, o_mem_we, o_mem_zext,
    input  o_timeout
  );

endinterface

// File: rtl/mem_port_arbiter_select.sv
// mem_arb_select: combinational choice of which port wins an IDLE grant.
// ARB_ROUND_ROBIN_EN: ties go to the port not granted last; otherwise DATA always wins.
module mem_arb_select
  import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_owner_e i_rr_ptr,
`endif
  input  logic       i_inst_req,
  input  logic       i_data_req,
  output arb_owner_e o_grant
);

  // Pick the winner among the currently requesting ports
  always_comb begin
    o_grant = OWN_NONE;
    if (i_inst_req && i_data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      o_grant = (i_rr_ptr == OWN_DATA) ? OWN_INST : OWN_DATA;
`else
      // Memory stage drains first so the pipeline never stalls behind a fetch
      o_grant = OWN_DATA;
`endif
    end else if (i_data_req) begin
      o_grant = OWN_DATA;
    end else if (i_inst_req) begin
      o_grant = OWN_INST;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory bus between instruction fetch and
// load/store. Grants are registered; the memory ack is returned combinationally to the owner.
// A transaction unanswered for TIMEOUT_CYCLES busy cycles is aborted with a one-cycle o_timeout.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed DATA priority).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               i_clk,
  input logic               i_rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  arb_owner_e        grant;
  logic [TimerW-1:0] timer_q;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [1:0]        mem_width_q;
  logic              mem_we_q;
  logic              mem_zext_q;
  logic              ack_hit;
  logic              timeout_hit;
  logic              done;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e        rr_ptr_q;
`endif

  mem_arb_select u_select (
`ifdef ARB_ROUND_ROBIN_EN
    .i_rr_ptr   (rr_ptr_q),
`endif
    .i_inst_req (bus.i_inst_req),
    .i_data_req (bus.i_data_req),
    .o_grant    (grant)
  );

  // Completion decode: a real ack always beats a timeout in the same cycle
  always_comb begin
    ack_hit     = (state_q == ARB_BUSY) && bus.i_mem_ack;
    timeout_hit = (state_q == ARB_BUSY) && !bus.i_mem_ack && (TIMEOUT_CYCLES != 0) &&
                  (timer_q == TimerLast);
    done        = ack_hit || timeout_hit;
  end

  // Route the completion to the owner only; rdata stays 0 without a real ack
  always_comb begin
    bus.o_inst_ack   = done && (owner_q == OWN_INST);
    bus.o_data_ack   = done && (owner_q == OWN_DATA);
    bus.o_inst_rdata = (ack_hit && (owner_q == OWN_INST)) ? bus.i_mem_rdata : '0;
    bus.o_data_rdata = (ack_hit && (owner_q == OWN_DATA)) ? bus.i_mem_rdata : '0;
    bus.o_timeout    = timeout_hit;
  end

  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_width = mem_width_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_zext  = mem_zext_q;

  // IDLE/BUSY FSM with registered memory-side request and fields
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_width_q <= '0;
      mem_we_q    <= 1'b0;
      mem_zext_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr_q    <= OWN_DATA;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant != OWN_NONE) begin
            state_q   <= ARB_BUSY;
            owner_q   <= grant;
            timer_q   <= '0;
            mem_req_q <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q  <= grant;
`endif
            if (grant == OWN_DATA) begin
              mem_addr_q  <= bus.i_data_addr;
              mem_wdata_q <= bus.i_data_wdata;
              mem_width_q <= bus.i_data_width;
              mem_we_q    <= bus.i_data_we;
              mem_zext_q  <= bus.i_data_zext;
            end else begin
              mem_addr_q  <= bus.i_inst_addr;
              mem_wdata_q <= '0;
              mem_width_q <= MEM_W_WORD;
              mem_we_q    <= 1'b0;
              mem_zext_q  <= 1'b0;
            end
          end
        end
        ARB_BUSY: begin
          if (done) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_NONE;
            mem_req_q <= 1'b0;
          end else if (timer_q != '1) begin
            // Saturate rather than wrap when the timeout is disabled
            timer_q <= timer_q + TimerW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus_if ();

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: busy flag, owner (1=inst, 2=data), cycles waited, latched fields
  bit          m_busy;
  int          m_owner;
  int unsigned m_wait;
  int          m_last;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_width;
  logic        m_we, m_zext;
  bit          check_en = 1'b0;

  task automatic model_reset();
    m_busy = 1'b0;
    m_owner = 0;
    m_wait = 0;
    m_last = 2;
  endtask

  task automatic model_step();
    logic        e_iack, e_dack, e_to;
    logic [31:0] e_irdata, e_drdata, rd;
    bit          done;
    int          w;
    e_iack = 1'b0; e_dack = 1'b0; e_to = 1'b0;
    e_irdata = '0; e_drdata = '0; rd = '0; done = 1'b0;
    if (m_busy) begin
      if (bus_if.i_mem_ack) begin
        done = 1'b1;
        rd = bus_if.i_mem_rdata;
      end else if (TO != 0 && m_wait == TO - 1) begin
        done = 1'b1;
        e_to = 1'b1;
      end
      if (done && m_owner == 1) begin e_iack = 1'b1; e_irdata = rd; end
      if (done && m_owner == 2) begin e_dack = 1'b1; e_drdata = rd; end
    end
    check1("m_mem_req", bus_if.o_mem_req, m_busy);
    if (m_busy) begin
      check("m_mem_addr", bus_if.o_mem_addr, m_addr);
      check("m_mem_width", 32'(bus_if.o_mem_width), 32'(m_width));
      check1("m_mem_we", bus_if.o_mem_we, m_we);
      check1("m_mem_zext", bus_if.o_mem_zext, m_zext);
      if (m_owner == 2) check("m_mem_wdata", bus_if.o_mem_wdata, m_wdata);
    end
    check1("m_inst_ack", bus_if.o_inst_ack, e_iack);
    check1("m_data_ack", bus_if.o_data_ack, e_dack);
    check("m_inst_rdata", bus_if.o_inst_rdata, e_irdata);
    check("m_data_rdata", bus_if.o_data_rdata, e_drdata);
    check1("m_timeout", bus_if.o_timeout, e_to);
    // Advance to the next cycle
    if (m_busy) begin
      if (done) begin
        m_busy = 1'b0;
        m_owner = 0;
      end else if (m_wait != 32'hFFFF_FFFF) begin
        m_wait++;
      end
    end else if (bus_if.i_inst_req || bus_if.i_data_req) begin
      if (bus_if.i_inst_req && bus_if.i_data_req) w = RR ? ((m_last == 2) ? 1 : 2) : 2;
      else w = bus_if.i_data_req ? 2 : 1;
      m_busy = 1'b1;
      m_owner = w;
      m_wait = 0;
      m_last = w;
      if (w == 2) begin
        m_addr = bus_if.i_data_addr;
        m_wdata = bus_if.i_data_wdata;
        m_width = bus_if.i_data_width;
        m_we = bus_if.i_data_we;
        m_zext = bus_if.i_data_zext;
      end else begin
        m_addr = bus_if.i_inst_addr;
        m_width = 2'd2;
        m_we = 1'b0;
        m_zext = 1'b0;
      end
    end
  endtask

  logic iack_seen = 1'b0;
  logic dack_seen = 1'b0;

  // Compare process, sampled mid-cycle
  always @(negedge clk) begin
    iack_seen = bus_if.o_inst_ack;
    dack_seen = bus_if.o_data_ack;
    if (check_en && rst_n) model_step();
  end

  // Memory responder: 0=random latency 0..6 with stray idle acks, 1=fixed latency, 2=never, 3=manual
  int mem_mode = 3;
  int mem_lat = 0;
  int mem_cnt = 0;
  int mem_tgt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_mode != 3) begin
      bus_if.i_mem_rdata = $urandom();
      if (!bus_if.o_mem_req) begin
        mem_cnt = 0;
        bus_if.i_mem_ack = (mem_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        if (mem_cnt == 0) begin
          mem_tgt = (mem_mode == 0) ? int'($urandom_range(0, 6)) :
                    (mem_mode == 1) ? mem_lat : 1000;
        end
        bus_if.i_mem_ack = (mem_cnt == mem_tgt);
        mem_cnt++;
      end
    end
  end

  // Random requesters: hold until acked, then drop or issue a new request
  bit req_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    if (req_rand) begin
      if (!bus_if.i_inst_req || iack_seen) begin
        bus_if.i_inst_req = 1'($urandom_range(0, 1));
        bus_if.i_inst_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!bus_if.i_data_req || dack_seen) begin
        bus_if.i_data_req = 1'($urandom_range(0, 1));
        bus_if.i_data_addr = $urandom();
        bus_if.i_data_wdata = $urandom();
        bus_if.i_data_width = 2'($urandom_range(0, 2));
        bus_if.i_data_we = 1'($urandom_range(0, 1));
        bus_if.i_data_zext = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic pclk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    bus_if.i_inst_req = 1'b0;   bus_if.i_inst_addr = '0;
    bus_if.i_data_req = 1'b0;   bus_if.i_data_addr = '0;
    bus_if.i_data_wdata = '0;   bus_if.i_data_width = '0;
    bus_if.i_data_we = 1'b0;    bus_if.i_data_zext = 1'b0;
    bus_if.i_mem_ack = 1'b0;    bus_if.i_mem_rdata = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check1("rst_mem_req", bus_if.o_mem_req, 1'b0);
    check("rst_mem_addr", bus_if.o_mem_addr, 32'h0);
    check("rst_mem_wdata", bus_if.o_mem_wdata, 32'h0);
    check("rst_mem_width", 32'(bus_if.o_mem_width), 32'h0);
    check1("rst_acks", bus_if.o_inst_ack | bus_if.o_data_ack, 1'b0);
    check1("rst_timeout", bus_if.o_timeout, 1'b0);
    pclk();
    rst_n = 1'b1;
    model_reset();
    check_en = 1'b1;

    // Single fetch, memory acks 2 cycles after the request
    mem_mode = 1; mem_lat = 2;
    bus_if.i_inst_req = 1'b1; bus_if.i_inst_addr = 32'h1000_0000;
    @(negedge clk); check1("t1_req_low", bus_if.o_mem_req, 1'b0);
    @(negedge clk); check1("t1_req", bus_if.o_mem_req, 1'b1);
    check("t1_addr", bus_if.o_mem_addr, 32'h1000_0000);
    check("t1_width", 32'(bus_if.o_mem_width), 32'd2);
    check1("t1_we", bus_if.o_mem_we, 1'b0);
    @(negedge clk); check1("t1_no_ack", bus_if.o_inst_ack, 1'b0);
    @(negedge clk); check1("t1_ack", bus_if.o_inst_ack, 1'b1);
    check("t1_rdata", bus_if.o_inst_rdata, bus_if.i_mem_rdata);
    pclk(); bus_if.i_inst_req = 1'b0;
    pclk();

    // Simultaneous fetch and store
    mem_lat = 0;
    bus_if.i_inst_req = 1'b1; bus_if.i_inst_addr = 32'h1000_0004;
    bus_if.i_data_req = 1'b1; bus_if.i_data_addr = 32'h2000_0004;
    bus_if.i_data_wdata = 32'hDEAD_BEEF; bus_if.i_data_width = 2'd2;
    bus_if.i_data_we = 1'b1; bus_if.i_data_zext = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t2_first_addr", bus_if.o_mem_addr, RR ? 32'h1000_0004 : 32'h2000_0004);
    check1("t2_first_we", bus_if.o_mem_we, !RR);
    check1("t2_first_iack", bus_if.o_inst_ack, RR);
    check1("t2_first_dack", bus_if.o_data_ack, !RR);
    pclk();
    if (RR) bus_if.i_inst_req = 1'b0; else bus_if.i_data_req = 1'b0;
    @(negedge clk); check1("t2_gap", bus_if.o_mem_req, 1'b0);
    @(negedge clk);
    check("t2_second_addr", bus_if.o_mem_addr, RR ? 32'h2000_0004 : 32'h1000_0004);
    check1("t2_second_iack", bus_if.o_inst_ack, !RR);
    check1("t2_second_dack", bus_if.o_data_ack, RR);
    pclk(); bus_if.i_inst_req = 1'b0; bus_if.i_data_req = 1'b0;
    pclk();

    // Load arrives while a fetch is in flight
    mem_lat = 3;
    bus_if.i_inst_req = 1'b1; bus_if.i_inst_addr = 32'h1000_0008;
    @(negedge clk);
    pclk();
    bus_if.i_data_req = 1'b1; bus_if.i_data_addr = 32'h2000_0010;
    bus_if.i_data_width = 2'd0; bus_if.i_data_we = 1'b0; bus_if.i_data_zext = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("t3_addr_held", bus_if.o_mem_addr, 32'h1000_0008);
    end
    check1("t3_fetch_ack", bus_if.o_inst_ack, 1'b1);
    pclk(); bus_if.i_inst_req = 1'b0;
    @(negedge clk); check1("t3_gap", bus_if.o_mem_req, 1'b0);
    @(negedge clk);
    check("t3_data_addr", bus_if.o_mem_addr, 32'h2000_0010);
    check("t3_data_width", 32'(bus_if.o_mem_width), 32'd0);
    check1("t3_data_zext", bus_if.o_mem_zext, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus_if.o_data_ack) found = 1'b1;
    end
    check1("t3_data_ack", found, 1'b1);
    pclk(); bus_if.i_data_req = 1'b0;
    pclk();

    // Memory never answers: abort on the TO-th busy cycle
    mem_mode = 2;
    bus_if.i_inst_req = 1'b1; bus_if.i_inst_addr = 32'h1000_000C;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check1("t4_no_timeout", bus_if.o_timeout, 1'b0);
    end
    @(negedge clk);
    check1("t4_timeout", bus_if.o_timeout, 1'b1);
    check1("t4_ack", bus_if.o_inst_ack, 1'b1);
    check("t4_rdata", bus_if.o_inst_rdata, 32'h0);
    pclk(); bus_if.i_inst_req = 1'b0;
    @(negedge clk); check1("t4_idle", bus_if.o_mem_req, 1'b0);
    pclk();

    // Back-to-back fetches with one-cycle memory: one grant every 3 cycles
    mem_mode = 1; mem_lat = 1;
    for (int k = 0; k < 3; k++) begin
      bus_if.i_inst_req = 1'b1; bus_if.i_inst_addr = 32'(k * 4);
      @(negedge clk); check1("t6_idle", bus_if.o_mem_req, 1'b0);
      @(negedge clk); check("t6_addr", bus_if.o_mem_addr, 32'(k * 4));
      check1("t6_no_ack", bus_if.o_inst_ack, 1'b0);
      @(negedge clk); check1("t6_ack", bus_if.o_inst_ack, 1'b1);
      pclk();
    end
    bus_if.i_inst_req = 1'b0;
    pclk();

    // Asynchronous reset while busy, then a late memory ack
    mem_mode = 3; bus_if.i_mem_ack = 1'b0;
    bus_if.i_inst_req = 1'b1; bus_if.i_inst_addr = 32'h1000_0100;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    check_en = 1'b0;
    #1;
    check1("t5_req_async", bus_if.o_mem_req, 1'b0);
    model_reset();
    pclk(); bus_if.i_inst_req = 1'b0;
    pclk();
    rst_n = 1'b1;
    bus_if.i_mem_ack = 1'b1; bus_if.i_mem_rdata = 32'h5555_AAAA;
    model_reset();
    check_en = 1'b1;
    @(negedge clk);
    check1("t5_late_iack", bus_if.o_inst_ack, 1'b0);
    check("t5_late_rdata", bus_if.o_inst_rdata, 32'h0);
    pclk(); bus_if.i_mem_ack = 1'b0;

    // Randomized traffic against the model
    mem_mode = 0;
    req_rand = 1'b1;
    repeat (3000) @(posedge clk);
    req_rand = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
